vicuna_ctrl: RTL



---
 rtl/tlul_pkg.sv | 45 ++++
 rtl/vicuna_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL payload types used on the management peripherals crossbar.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_AIW = 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/vicuna_ctrl.sv
// Run control for the Vicuna worker cores: per-core reset sequencing, done interrupts, TL-UL registers.
// Optional per-core run-time cycle counters are built when VICUNA_CTRL_CYCLE_CNT_EN is defined.
module vicuna_ctrl
    import tlul_pkg::*;
#(
    parameter int unsigned NumCores      = 2,
    parameter int unsigned RstHoldCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tl_h2d_t             tl_i,
    output tl_d2h_t             tl_o,
    output logic [NumCores-1:0] core_rst_no,
    input  logic [NumCores-1:0] core_done_i,
    output logic                irq_o
);

    localparam int unsigned HoldW = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
    localparam int unsigned CntW  = 32;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(RstHoldCycles - 1);

    localparam logic [7:0] AddrStart   = 8'h00;
    localparam logic [7:0] AddrStop    = 8'h04;
    localparam logic [7:0] AddrStatus  = 8'h08;
    localparam logic [7:0] AddrIrqPend = 8'h0C;
    localparam logic [7:0] AddrIrqEn   = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } core_state_e;

    core_state_e         r_state [NumCores];
    logic [HoldW-1:0]    r_hold_cnt [NumCores];
    logic [NumCores-1:0] r_core_rst_n;
    logic [NumCores-1:0] r_irq_pend;
    logic [NumCores-1:0] r_irq_en;
    logic                r_irq;

    logic                r_rsp_valid;
    tl_d_op_e            r_rsp_op;
    logic [TL_SZW-1:0]   r_rsp_size;
    logic [TL_AIW-1:0]   r_rsp_source;
    logic [TL_DW-1:0]    r_rsp_data;
    logic                r_rsp_error;

    logic [7:0]          w_addr;
    logic [2:0]          w_cyc_idx;
    logic                w_accept, w_is_get, w_is_put;
    logic                w_hit_start, w_hit_stop, w_hit_status, w_hit_pend, w_hit_en, w_hit_cyc;
    logic                w_mapped, w_read_only, w_err, w_wr;
    logic [NumCores-1:0] w_start, w_stop, w_clr;
    logic [NumCores-1:0] w_enter_hold, w_done_set;
    logic [NumCores-1:0] w_pend_nxt, w_en_nxt;
    logic [TL_DW-1:0]    w_rdata;
    logic                w_unused_tl;

    // Request decode; the crossbar has already matched the device window.
    assign w_addr       = tl_i.a_address[7:0];
    assign w_cyc_idx    = w_addr[4:2];
    assign w_accept     = tl_i.a_valid & ~r_rsp_valid;
    assign w_is_get     = (tl_i.a_opcode == Get);
    assign w_is_put     = (tl_i.a_opcode == PutFullData);
    assign w_hit_start  = (w_addr == AddrStart);
    assign w_hit_stop   = (w_addr == AddrStop);
    assign w_hit_status = (w_addr == AddrStatus);
    assign w_hit_pend   = (w_addr == AddrIrqPend);
    assign w_hit_en     = (w_addr == AddrIrqEn);
    assign w_hit_cyc    = (w_addr[7:5] == 3'b001) && (w_addr[1:0] == 2'b00)
                          && (32'(w_cyc_idx) < NumCores);
    assign w_mapped     = w_hit_start | w_hit_stop | w_hit_status | w_hit_pend | w_hit_en | w_hit_cyc;
    assign w_read_only  = w_hit_status | w_hit_cyc;
    assign w_err        = ~(w_is_get | w_is_put) | (tl_i.a_mask != 4'hF) | (tl_i.a_size != 2'd2)
                          | ~w_mapped | (w_is_put & w_read_only);
    assign w_wr         = w_accept & w_is_put & ~w_err;

    assign w_start = (w_wr & w_hit_start) ? tl_i.a_data[NumCores-1:0] : '0;
    assign w_stop  = (w_wr & w_hit_stop)  ? tl_i.a_data[NumCores-1:0] : '0;
    assign w_clr   = (w_wr & w_hit_pend)  ? tl_i.a_data[NumCores-1:0] : '0;

    // STOP overrides both a START and a completion landing in the same cycle.
    always_comb begin
        w_enter_hold = '0;
        w_done_set   = '0;
        for (int n = 0; n < NumCores; n++) begin
            w_enter_hold[n] = w_start[n] & ~w_stop[n]
                              & ((r_state[n] == ST_IDLE) | (r_state[n] == ST_DONE));
            w_done_set[n]   = core_done_i[n] & ~w_stop[n] & (r_state[n] == ST_RUN);
        end
    end

    assign w_pend_nxt = w_done_set | (r_irq_pend & ~w_clr);
    assign w_en_nxt   = (w_wr & w_hit_en) ? tl_i.a_data[NumCores-1:0] : r_irq_en;

    // Per-core run-control FSMs; core reset is driven straight from a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NumCores; n++) begin
                r_state[n]    <= ST_IDLE;
                r_hold_cnt[n] <= '0;
            end
            r_core_rst_n <= '0;
        end else begin
            for (int n = 0; n < NumCores; n++) begin
                if (w_stop[n]) begin
                    r_state[n]      <= ST_IDLE;
                    r_core_rst_n[n] <= 1'b0;
                end else begin
                    case (r_state[n])
                        ST_IDLE, ST_DONE: begin
                            if (w_enter_hold[n]) begin
                                r_state[n]    <= ST_HOLD;
                                r_hold_cnt[n] <= HoldLoad;
                            end
                        end
                        ST_HOLD: begin
                            if (r_hold_cnt[n] == '0) begin
                                r_state[n]      <= ST_RUN;
                                r_core_rst_n[n] <= 1'b1;
                            end else begin
                                r_hold_cnt[n] <= r_hold_cnt[n] - HoldW'(1);
                            end
                        end
                        ST_RUN: begin
                            if (w_done_set[n]) begin
                                r_state[n]      <= ST_DONE;
                                r_core_rst_n[n] <= 1'b0;
                            end
                        end
                        default: r_state[n] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Interrupt state; irq_o is precomputed so it lands with the pending bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_pend <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_pend <= w_pend_nxt;
            r_irq_en   <= w_en_nxt;
            r_irq      <= |(w_pend_nxt & w_en_nxt);
        end
    end

`ifdef VICUNA_CTRL_CYCLE_CNT_EN
    logic [CntW-1:0] r_cycles [NumCores];

    // Saturating run-time counters, frozen outside RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NumCores; n++) r_cycles[n] <= '0;
        end else begin
            for (int n = 0; n < NumCores; n++) begin
                if (w_enter_hold[n]) begin
                    r_cycles[n] <= '0;
                end else if ((r_state[n] == ST_RUN) && !w_stop[n] && (r_cycles[n] != '1)) begin
                    r_cycles[n] <= r_cycles[n] + CntW'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (w_hit_status) begin
            for (int n = 0; n < NumCores; n++) w_rdata[2*n +: 2] = r_state[n];
        end else if (w_hit_pend) begin
            w_rdata[NumCores-1:0] = r_irq_pend;
        end else if (w_hit_en) begin
            w_rdata[NumCores-1:0] = r_irq_en;
        end
`ifdef VICUNA_CTRL_CYCLE_CNT_EN
        else if (w_hit_cyc) begin
            for (int n = 0; n < NumCores; n++) begin
                if (w_cyc_idx == 3'(n)) w_rdata = r_cycles[n];
            end
        end
`endif
    end

    // Single outstanding response slot; data is captured at acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= AccessAck;
            r_rsp_size   <= '0;
            r_rsp_source <= '0;
            r_rsp_data   <= '0;
            r_rsp_error  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_op     <= w_is_get ? AccessAckData : AccessAck;
            r_rsp_size   <= tl_i.a_size;
            r_rsp_source <= tl_i.a_source;
            r_rsp_data   <= (w_is_get && !w_err) ? w_rdata : '0;
            r_rsp_error  <= w_err;
        end else if (tl_i.d_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = r_rsp_valid;
        tl_o.d_opcode = r_rsp_op;
        tl_o.d_size   = r_rsp_size;
        tl_o.d_source = r_rsp_source;
        tl_o.d_data   = r_rsp_data;
        tl_o.d_error  = r_rsp_error;
        tl_o.a_ready  = ~r_rsp_valid;
    end

    assign core_rst_no = r_core_rst_n;
    assign irq_o       = r_irq;

    assign w_unused_tl = ^{tl_i.a_param, tl_i.a_address, tl_i.a_data};

endmodule
